// File: rtl/rib_pkg.sv
// Shared types and constants for the RIB interconnect arbiter.
// No logic: pure declarations, zero latency.
// No flow control of its own.
package rib_pkg;

    localparam int NUM_M     = 3;
    localparam int M_CPU     = 0;
    localparam int M_DBG     = 1;
    localparam int M_DMA     = 2;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner select: starving CPU first, else fixed priority m1 > m2 > m0.
// Zero latency.
// No backpressure; it only looks at the current request vector.
module rib_arb_pick
    import rib_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic             starve,
    output logic [NUM_M-1:0] pick_oh,
    output logic [1:0]       pick_idx,
    output logic             any
);

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        any      = |req;
        if (starve && req[M_CPU]) begin
            pick_oh[M_CPU] = 1'b1;
            pick_idx       = 2'(M_CPU);
        end else if (req[M_DBG]) begin
            pick_oh[M_DBG] = 1'b1;
            pick_idx       = 2'(M_DBG);
        end else if (req[M_DMA]) begin
            pick_oh[M_DMA] = 1'b1;
            pick_idx       = 2'(M_DMA);
        end else if (req[M_CPU]) begin
            pick_oh[M_CPU] = 1'b1;
            pick_idx       = 2'(M_CPU);
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Three-master RIB bus arbiter with burst limit, CPU anti-starvation and one dead cycle between owners.
// Grant is registered: 1 cycle from request to grant out of IDLE.
// Requesters are held off by grant absence; cpu_hold_o stalls the core combinationally.
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int MAX_WAIT  = 8,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req_i,
    output logic [NUM_M-1:0] grant_o,
    output logic             grant_vld_o,
    output logic [1:0]       grant_id_o,
    output logic             cpu_hold_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] WAIT_SAT   = CNT_W'(MAX_WAIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt, burst_d;
    logic [CNT_W-1:0] wait_cnt, wait_d;
    logic [NUM_M-1:0] grant_d;
    logic [1:0]       grant_id_d;

    logic             starve;
    logic [NUM_M-1:0] pick_oh;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             other_req;
    logic             burst_end;

    assign starve = req_i[M_CPU] && (wait_cnt == WAIT_SAT);

    rib_arb_pick u_pick (
        .req      (req_i),
        .starve   (starve),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign owner_req = |(req_i & grant_o);
    assign other_req = |(req_i & ~grant_o);
    assign burst_end = (burst_cnt == BURST_LAST);

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_cnt;
        grant_d    = grant_o;
        grant_id_d = grant_id_o;
        case (state_q)
            IDLE, TURN: begin
                // IDLE and TURN both arbitrate afresh; TURN just falls back to IDLE when nobody asks.
                if (pick_any) begin
                    state_d    = OWN;
                    grant_d    = pick_oh;
                    grant_id_d = pick_idx;
                    burst_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!owner_req || (burst_end && other_req)) begin
                    state_d    = TURN;
                    grant_d    = '0;
                    grant_id_d = '0;
                end else if (burst_end) begin
                    burst_d = '0;
                end else begin
                    burst_d = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase
    end

    always_comb begin
        wait_d = '0;
        if (req_i[M_CPU] && !grant_o[M_CPU])
            wait_d = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_o     <= '0;
            grant_id_o  <= '0;
            grant_vld_o <= 1'b0;
            busy_o      <= 1'b0;
            burst_cnt   <= '0;
            wait_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            grant_o     <= grant_d;
            grant_id_o  <= grant_id_d;
            grant_vld_o <= |grant_d;
            busy_o      <= (state_d != IDLE);
            burst_cnt   <= burst_d;
            wait_cnt    <= wait_d;
        end
    end

    assign cpu_hold_o = req_i[M_CPU] & ~grant_o[M_CPU];

endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter: directed scenarios plus randomized requests against a behavioural model.
module tb_rib_arbiter;
    import rib_pkg::*;

    localparam int MB = 4;
    localparam int MW = 8;
    localparam int CW = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic       cpu_hold;
    logic       busy;

    always #10 clk = ~clk;

    rib_arbiter #(.MAX_BURST(MB), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .grant_o     (grant),
        .grant_vld_o (grant_vld),
        .grant_id_o  (grant_id),
        .cpu_hold_o  (cpu_hold),
        .busy_o      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), whether a dead cycle is in progress,
    // cycles already spent by the owner in the current burst window, and CPU denied count.
    int m_owner = -1;
    bit m_turn  = 1'b0;
    int m_run   = 0;
    int m_wait  = 0;

    function automatic int pick(input logic [2:0] r, input int w);
        if (r[0] && w == MW) return 0;
        if (r[1]) return 1;
        if (r[2]) return 2;
        if (r[0]) return 0;
        return -1;
    endfunction

    function automatic logic [2:0] own_vec(input int o);
        logic [2:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        int nxt_wait;
        logic [2:0] ov;
        if (rst) begin
            m_owner = -1;
            m_turn  = 1'b0;
            m_run   = 0;
            m_wait  = 0;
        end else begin
            nxt_wait = (req[0] && m_owner != 0) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
            if (m_owner >= 0) begin
                ov = own_vec(m_owner);
                if (!req[m_owner] || (m_run == MB - 1 && (req & ~ov) != 3'b000)) begin
                    m_owner = -1;
                    m_turn  = 1'b1;
                end else begin
                    m_run = (m_run == MB - 1) ? 0 : m_run + 1;
                end
            end else begin
                m_owner = pick(req, m_wait);
                m_turn  = 1'b0;
                m_run   = 0;
            end
            m_wait = nxt_wait;
        end
    end

    int         deny   = 0;
    logic [2:0] prev_g = 3'b000;

    always @(posedge clk) begin
        logic [2:0] eg;
        #1;
        eg = own_vec(m_owner);
        chk("mdl_grant", 32'(grant), 32'(eg));
        chk("mdl_id", 32'(grant_id), (m_owner >= 0) ? m_owner : 0);
        chk("mdl_vld", 32'(grant_vld), 32'(m_owner >= 0));
        chk("mdl_busy", 32'(busy), 32'(m_owner >= 0 || m_turn));
        chk("mdl_hold", 32'(cpu_hold), 32'(req[0] & ~eg[0]));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        chk("dead_cycle_between", 32'(prev_g != 3'b000 && grant != 3'b000 && grant != prev_g), 32'd0);
        deny = (req[0] && !grant[0]) ? deny + 1 : 0;
        chk("m0_wait_bound", 32'(deny <= MW + MB + 2), 32'd1);
        prev_g = grant;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] seq111 [26] = '{
        3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
        3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
        3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
        3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
        3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
        3'b001
    };

    initial begin
        logic [2:0] r;
        rst = 1'b1;
        req = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(posedge clk); #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_vld", 32'(grant_vld), 32'd0);
        chk("rst_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Lone CPU request: combinational hold, then grant one edge later
        @(negedge clk);
        req = 3'b001;
        #1;
        chk("cpu_hold_rise", 32'(cpu_hold), 32'd1);
        chk("cpu_grant_pre", 32'(grant), 32'd0);
        @(posedge clk); #2;
        chk("cpu_grant", 32'(grant), 32'b001);
        chk("cpu_hold_after", 32'(cpu_hold), 32'd0);
        chk("cpu_vld", 32'(grant_vld), 32'd1);

        // All three requesting: m1 bursts, starvation hands m0 the bus
        do_reset();
        @(negedge clk);
        req = 3'b111;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #2;
            chk("all_req_seq", 32'(grant), 32'(seq111[i]));
        end

        // m2 drops for one cycle while m1 asks
        do_reset();
        @(negedge clk);
        req = 3'b100;
        @(posedge clk); #2;
        chk("m2_grant", 32'(grant), 32'b100);
        chk("m2_id", 32'(grant_id), 32'd2);
        @(negedge clk);
        req = 3'b010;
        @(posedge clk); #2;
        chk("m2_release_gap", 32'(grant), 32'b000);
        chk("m2_release_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req = 3'b110;
        @(posedge clk); #2;
        chk("m1_after_gap", 32'(grant), 32'b010);

        // Lone CPU keeps the bus across burst wraps
        do_reset();
        @(negedge clk);
        req = 3'b001;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            chk("cpu_solo_hold", 32'(grant), 32'b001);
        end

        // Reset pulse mid-burst
        do_reset();
        @(negedge clk);
        req = 3'b010;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_grant", 32'(grant), 32'b010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_vld", 32'(grant_vld), 32'd0);
        chk("mid_rst_id", 32'(grant_id), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("post_rst_grant", 32'(grant), 32'b010);
        chk("post_rst_id", 32'(grant_id), 32'd1);

        // Randomized level-held requests
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            r = req;
            for (int k = 0; k < 3; k++)
                if ($urandom_range(5) == 0) r[k] = ~r[k];
            req = r;
        end
        @(negedge clk);
        req = 3'b000;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
